// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive controller.
// Optional build macro: USB_RX_STUFF_ERR_EN (bit-stuffing violation detection).
package usb_rx_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StChkSync,
    StRxByte,
    StStore,
    StEopWait,
    StErrDrain,
    StErrEopWait,
    StErrIdle
  } rx_state_e;

  localparam logic [7:0] SyncByteDefault = 8'h80;

  // Longest run of samples without a line transition before the stream is illegal.
  localparam logic [2:0] StuffLimit = 3'd7;

  // States in which a packet is considered in flight.
  function automatic logic rx_state_rcving(input rx_state_e st);
    return (st == StSync) || (st == StChkSync) || (st == StRxByte) || (st == StStore) ||
           (st == StEopWait) || (st == StErrDrain) || (st == StErrEopWait);
  endfunction

  // States that report a receive error.
  function automatic logic rx_state_err(input rx_state_e st);
    return (st == StErrDrain) || (st == StErrEopWait) || (st == StErrIdle);
  endfunction

  // States in which the bit timer advances and resynchronises on edges.
  function automatic logic rx_state_timer_en(input rx_state_e st);
    return (st == StSync) || (st == StRxByte) || (st == StStore) || (st == StErrDrain);
  endfunction

endpackage

// File: rtl/usb_rx_timer.sv
// Bit timer for the USB receiver: per-bit clock counter resynchronised on line
// edges, the bit-sample strobe, the bit-within-byte counter and the byte pulse.
module usb_rx_timer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       timer_en,
  input  logic       load_en,
  input  logic       bit_clr,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_cnt
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic            byte_received_q;

  // An edge never coincides with a sample: the edge restarts the bit period.
  assign shift_enable  = timer_en && (clk_cnt_q == CntW'(SAMPLE_POINT)) && !d_edge;
  assign byte_received = byte_received_q;
  assign bit_cnt       = bit_cnt_q;

  // Clock-within-bit counter: restart on an edge, otherwise wrap per bit period.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt_q <= '0;
    end else if (d_edge && load_en) begin
      clk_cnt_q <= '0;
    end else if (timer_en) begin
      if (clk_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
        clk_cnt_q <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + CntW'(1);
      end
    end
  end

  // Bit-within-byte counter and the byte-complete pulse one cycle after the 8th sample.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q       <= 3'd0;
      byte_received_q <= 1'b0;
    end else begin
      byte_received_q <= shift_enable && (bit_cnt_q == 3'd7);
      if (bit_clr) begin
        bit_cnt_q <= 3'd0;
      end else if (shift_enable) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control: sequences SYNC check, data bytes and EOP,
// strobes completed bytes into the RX FIFO and flags receive errors.
// Optional build macro: USB_RX_STUFF_ERR_EN adds a bit-stuffing violation check
// that forces the error path after too many samples without a line edge.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 2,
  parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  rx_state_e  state_q, state_d;
  logic       timer_en;
  logic       load_en;
  logic       bit_clr;
  logic [2:0] bit_cnt;

  assign timer_en = rx_state_timer_en(state_q);
  // Idle also listens for the first edge so the new packet starts bit-aligned.
  assign load_en  = timer_en || (state_q == StIdle);
  // Any edge that launches a new SYNC field restarts byte framing.
  assign bit_clr  = d_edge && ((state_q == StIdle) || (state_q == StErrIdle));

  usb_rx_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_edge        (d_edge),
    .timer_en      (timer_en),
    .load_en       (load_en),
    .bit_clr       (bit_clr),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_cnt       (bit_cnt)
  );

`ifdef USB_RX_STUFF_ERR_EN
  logic [2:0] stuff_cnt_q;
  logic       stuff_hit;

  assign stuff_hit = (stuff_cnt_q == StuffLimit);

  // Samples since the last line edge, saturating at the stuffing limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stuff_cnt_q <= 3'd0;
    end else if (d_edge) begin
      stuff_cnt_q <= 3'd0;
    end else if (shift_enable && !stuff_hit) begin
      stuff_cnt_q <= stuff_cnt_q + 3'd1;
    end
  end
`endif

  // Next-state decode for packet sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_edge) state_d = StSync;
      end
      StSync: begin
        if (byte_received)           state_d = StChkSync;
        else if (shift_enable && eop) state_d = StErrEopWait;
      end
      StChkSync: begin
        state_d = (rcv_data == SYNC_BYTE) ? StRxByte : StErrDrain;
      end
      StRxByte: begin
        if (byte_received) begin
          state_d = StStore;
        end else if (shift_enable && eop) begin
          // EOP is only clean on a byte boundary; mid-byte it truncates data.
          state_d = (bit_cnt == 3'd0) ? StEopWait : StErrEopWait;
        end
      end
      StStore: begin
        state_d = StRxByte;
      end
      StEopWait: begin
        if (d_edge) state_d = StIdle;
      end
      StErrDrain: begin
        if (shift_enable && eop) state_d = StErrEopWait;
      end
      StErrEopWait: begin
        if (d_edge) state_d = StErrIdle;
      end
      StErrIdle: begin
        if (d_edge) state_d = StSync;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
`ifdef USB_RX_STUFF_ERR_EN
    if (stuff_hit && ((state_q == StRxByte) || (state_q == StStore))) begin
      state_d = StErrDrain;
    end
`endif
  end

  // State register with Moore outputs registered alongside it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      rcving   <= 1'b0;
      r_error  <= 1'b0;
      w_enable <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcving   <= rx_state_rcving(state_d);
      r_error  <= rx_state_err(state_d);
      w_enable <= (state_d == StStore);
    end
  end

endmodule
